// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider:
//   RATIO_W       - default width of the divide-ratio field
//   DEFAULT_RATIO - ratio loaded while reset is asserted
//   MIN_RATIO     - smallest accepted ratio (0 and 1 are rejected)
//   ctrl_state_t  - ratio-change handshake FSM states
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int RATIO_W       = 8;
    localparam int DEFAULT_RATIO = 6;
    localparam int MIN_RATIO     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/clk_div_ctrl_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Period counter, active-ratio register and registered divided-clock output.
//
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   en           - run enable (level); a falling en lets the period finish
//   load         - load load_ratio as the active ratio on this edge; the
//                  controller only raises it on a period boundary or while
//                  the divider is stopped, so the counter restarts at 0
//   load_ratio   - ratio to load
//   clk_out      - divided clock, high while cnt < floor(N/2)
//   running      - divider is counting
//   boundary     - current cycle is the last of the period (cnt == N-1)
// -----------------------------------------------------------------------------
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int RATIO_W       = clk_div_pkg::RATIO_W,
    parameter int DEFAULT_RATIO = clk_div_pkg::DEFAULT_RATIO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [RATIO_W-1:0] load_ratio,
    output logic               clk_out,
    output logic               running,
    output logic               boundary
);

    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] ratio;

    logic [RATIO_W-1:0] cnt_nxt;
    logic [RATIO_W-1:0] ratio_nxt;
    logic               run_nxt;
    logic               clk_nxt;

    assign boundary = running && (cnt == ratio - RATIO_W'(1));

    always_comb begin
        ratio_nxt = load ? load_ratio : ratio;
        cnt_nxt   = '0;
        run_nxt   = en;
        if (running && !boundary) begin
            // Mid-period: keep counting even if en has dropped, so the
            // current period always completes with full-length phases.
            cnt_nxt = cnt + RATIO_W'(1);
            run_nxt = 1'b1;
        end
        // The output is derived from the next counter value so clk_out and
        // cnt always describe the same cycle.
        clk_nxt = run_nxt && (cnt_nxt < (ratio_nxt >> 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            ratio   <= RATIO_W'(DEFAULT_RATIO);
            running <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            ratio   <= ratio_nxt;
            running <= run_nxt;
            clk_out <= clk_nxt;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Programmable clock divider with a ratio-change handshake.
//
// Ports:
//   clk, rst   - system clock, asynchronous active-low reset
//   en         - divider run enable (level)
//   div_req    - ratio-change request (level)
//   div_ratio  - requested ratio, valid while div_req is high
//   div_ack    - one-cycle pulse: the new ratio is in effect this cycle
//   div_busy   - an accepted request is waiting for its period boundary
//   div_err    - one-cycle pulse: the request had ratio 0 or 1
//   clk_out    - divided clock (registered)
//   dbg_state  - current handshake FSM state (ctrl_state_t encoding)
//
// Handshake: div_req/div_ratio are sampled only in IDLE. A valid request is
// latched and the FSM waits in PEND for the first period boundary strictly
// after acceptance (or the next cycle if the divider is stopped), loads the
// ratio there and pulses div_ack in the first cycle of the new period. The
// requester drops div_req on div_ack; a request still high once the FSM is
// back in IDLE counts as a new one. Invalid ratios get div_err instead and
// leave everything else untouched.
// -----------------------------------------------------------------------------
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int RATIO_W       = clk_div_pkg::RATIO_W,
    parameter int DEFAULT_RATIO = clk_div_pkg::DEFAULT_RATIO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               div_req,
    input  logic [RATIO_W-1:0] div_ratio,
    output logic               div_ack,
    output logic               div_busy,
    output logic               div_err,
    output logic               clk_out,
    output logic [1:0]         dbg_state
);

    ctrl_state_t        state;
    logic [RATIO_W-1:0] req_ratio;
    logic               ratio_ok;
    logic               apply;
    logic               running;
    logic               boundary;

    assign ratio_ok  = (div_ratio >= RATIO_W'(MIN_RATIO));
    // Entering PEND happens on the edge that ends the acceptance cycle, so a
    // boundary seen while in PEND is always strictly after acceptance.
    assign apply     = (state == ST_PEND) && (boundary || !running);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            req_ratio <= RATIO_W'(DEFAULT_RATIO);
            div_ack   <= 1'b0;
            div_busy  <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            div_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (div_req) begin
                        if (ratio_ok) begin
                            req_ratio <= div_ratio;
                            div_busy  <= 1'b1;
                            state     <= ST_PEND;
                        end else begin
                            div_err <= 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (apply) begin
                        div_ack  <= 1'b1;
                        div_busy <= 1'b0;
                        state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    clk_div_core #(
        .RATIO_W       (RATIO_W),
        .DEFAULT_RATIO (DEFAULT_RATIO)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (apply),
        .load_ratio (req_ratio),
        .clk_out    (clk_out),
        .running    (running),
        .boundary   (boundary)
    );

endmodule
